// File: rtl/result_bcd_conv_if.sv
// rtl/result_bcd_conv_if.sv - result/BCD handshake bundle between ALU side and display side
interface result_bcd_conv_if;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_is_division;
  logic        busy;
  logic        out_valid;
  logic [39:0] out_bcd;
  logic [9:0]  out_blank;
  logic        out_dp;
  logic [3:0]  out_ndigits;

  modport master (
    output in_valid, in_result, in_is_division,
    input  busy, out_valid, out_bcd, out_blank, out_dp, out_ndigits
  );

  modport slave (
    input  in_valid, in_result, in_is_division,
    output busy, out_valid, out_bcd, out_blank, out_dp, out_ndigits
  );
endinterface

// File: rtl/result_bcd_conv.sv
// rtl/result_bcd_conv.sv - sequential double-dabble binary to 10-digit BCD with leading-zero blanking
module result_bcd_conv (
  input  logic             clk,
  input  logic             rst,
  result_bcd_conv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state_q;
  logic [31:0] bin_q;
  logic [39:0] acc_q;
  logic [5:0]  cnt_q;
  logic        dp_cap_q;

  logic        busy_q;
  logic        out_valid_q;
  logic [39:0] bcd_q;
  logic [9:0]  blank_q;
  logic        dp_q;
  logic [3:0]  ndig_q;

  logic [39:0] adj_d;
  logic [71:0] shift_d;
  logic [3:0]  hi_d;
  logic [9:0]  blank_d;
  logic [3:0]  nblank_d;
  logic [3:0]  ndig_d;

  // Add-3 correction on every digit >= 5, then shift {acc, bin} left by one.
  always_comb begin
    adj_d = '0;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else                         adj_d[4*i +: 4] = acc_q[4*i +: 4];
    end
    shift_d = {adj_d, bin_q} << 1;
  end

  // Blank every digit above the highest nonzero one; keep "0.x" visible for division results.
  always_comb begin
    hi_d     = 4'd0;
    blank_d  = '0;
    nblank_d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) hi_d = 4'(i);
    end
    for (int i = 0; i < 10; i++) begin
      blank_d[i] = (4'(i) > hi_d);
    end
    if (dp_cap_q) blank_d[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nblank_d = nblank_d + {3'd0, blank_d[i]};
    end
    ndig_d = 4'd10 - nblank_d;
  end

  // Conversion FSM with registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dp_cap_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= 10'h3FE;
      dp_q        <= 1'b0;
      ndig_q      <= 4'd1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q    <= bus.in_result;
            dp_cap_q <= bus.in_is_division;
            acc_q    <= '0;
            cnt_q    <= 6'd32;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= shift_d[71:32];
          bin_q <= shift_d[31:0];
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= FINISH;
        end
        FINISH: begin
          bcd_q       <= acc_q;
          blank_q     <= blank_d;
          dp_q        <= dp_cap_q;
          ndig_q      <= ndig_d;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bcd     = bcd_q;
  assign bus.out_blank   = blank_q;
  assign bus.out_dp      = dp_q;
  assign bus.out_ndigits = ndig_q;

endmodule
